// File: rtl/pixel_fifo_if.sv
// Handshake bundle between a rasterizer lane, the pixel FIFO and the contention tree.
// The master drives pushes and pop requests; the slave (the FIFO) answers with status and data.
interface pixel_fifo_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LENGTH      = 8
);
    logic [PIXEL_WIDTH-1:0] wr_pix;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [LENGTH-1:0]      fill;
    logic                   req;
    logic                   ack;
    logic [PIXEL_WIDTH-1:0] pix_out;

    modport master (
        output wr_pix, wr_valid, req,
        input  wr_ready, fill, ack, pix_out
    );

    modport slave (
        input  wr_pix, wr_valid, req,
        output wr_ready, fill, ack, pix_out
    );
endinterface

// File: rtl/pixel_fifo.sv
// Circular-buffer pixel FIFO with a 4-phase req/ack pop port.
// Each req assertion pops exactly one word, which is held on pix_out until the next pop.
module pixel_fifo #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LENGTH      = 8,
    parameter int DEPTH       = 16
) (
    input  logic         clk,
    input  logic         reset,
    pixel_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [DEPTH-1:0][PIXEL_WIDTH-1:0] mem;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LENGTH-1:0]      fill;
    logic [PIXEL_WIDTH-1:0] pix_out;
    logic                   ack;
    state_t                 state;
    logic                   wr_ready, do_wr, do_pop;

    assign wr_ready = (fill < LENGTH'(DEPTH)) && !reset;
    assign do_wr    = bus.wr_valid && wr_ready;
    // Pop decision uses the pre-edge fill, so a word written this edge is never popped this edge.
    assign do_pop   = (state == IDLE) && bus.req && (fill != '0) && !reset;

    assign bus.wr_ready = wr_ready;
    assign bus.fill     = fill;
    assign bus.ack      = ack;
    assign bus.pix_out  = pix_out;

    // Storage is not cleared by reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= bus.wr_pix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ack     <= 1'b0;
            pix_out <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                pix_out <= mem[rd_ptr];
            end

            case (state)
                IDLE: if (do_pop) begin
                    state <= HOLD;
                    ack   <= 1'b1;
                end
                HOLD: if (!bus.req) begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
            endcase

            if (do_wr && !do_pop)
                fill <= fill + LENGTH'(1);
            else if (do_pop && !do_wr)
                fill <= fill - LENGTH'(1);
        end
    end
endmodule

// File: tb/tb_pixel_fifo.sv
// Directed bench for pixel_fifo at DEPTH=4: fill, overflow drop, waiting pop,
// concurrent push/pop, pointer wrap and reset during HOLD.
module tb_pixel_fifo;
    localparam int PW = 8;
    localparam int LN = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    pixel_fifo_if #(.PIXEL_WIDTH(PW), .LENGTH(LN)) bus ();

    pixel_fifo #(.PIXEL_WIDTH(PW), .LENGTH(LN), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input int exp_fill);
        bus.wr_pix   = v;
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        chk("push_fill", 32'(bus.fill), 32'(exp_fill));
    endtask

    task automatic pop(input logic [7:0] exp, input int exp_fill);
        bus.req = 1'b1;
        tick();
        chk("pop_ack", 32'(bus.ack), 32'd1);
        chk("pop_pix", 32'(bus.pix_out), 32'(exp));
        chk("pop_fill", 32'(bus.fill), 32'(exp_fill));
        bus.req = 1'b0;
        tick();
        chk("pop_ack_drop", 32'(bus.ack), 32'd0);
        chk("pop_pix_hold", 32'(bus.pix_out), 32'(exp));
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_pix   = '0;
        bus.wr_valid = 1'b0;
        bus.req      = 1'b0;
        tick();
        tick();
        chk("rst_fill", 32'(bus.fill), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_pix", 32'(bus.pix_out), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("wr_ready_idle", 32'(bus.wr_ready), 32'd1);

        // basic fill and single pop
        push(8'h11, 1);
        push(8'h22, 2);
        push(8'h33, 3);
        pop(8'h11, 2);
        pop(8'h22, 1);
        pop(8'h33, 0);

        // overflow: fifth word dropped
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), i + 1);
        chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        push(8'hA4, 4);
        for (int i = 0; i < 4; i++) pop(8'hA0 + 8'(i), 3 - i);
        chk("empty_wr_ready", 32'(bus.wr_ready), 32'd1);

        // pop request waits on empty FIFO
        bus.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_ack", 32'(bus.ack), 32'd0);
        end
        bus.wr_pix   = 8'h5C;
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        chk("wait_fill", 32'(bus.fill), 32'd1);
        chk("no_write_through", 32'(bus.ack), 32'd0);
        tick();
        chk("wait_pop_ack", 32'(bus.ack), 32'd1);
        chk("wait_pop_pix", 32'(bus.pix_out), 32'h5C);
        chk("wait_pop_fill", 32'(bus.fill), 32'd0);
        bus.req = 1'b0;
        tick();
        chk("wait_ack_drop", 32'(bus.ack), 32'd0);

        // simultaneous write and pop at fill=2
        push(8'h01, 1);
        push(8'h02, 2);
        bus.wr_pix   = 8'h77;
        bus.wr_valid = 1'b1;
        bus.req      = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        chk("wp_fill", 32'(bus.fill), 32'd2);
        chk("wp_ack", 32'(bus.ack), 32'd1);
        chk("wp_pix", 32'(bus.pix_out), 32'h01);
        tick();
        chk("hold_ack", 32'(bus.ack), 32'd1);
        chk("hold_pix", 32'(bus.pix_out), 32'h01);
        chk("hold_fill", 32'(bus.fill), 32'd2);
        bus.req = 1'b0;
        tick();
        pop(8'h02, 1);
        pop(8'h77, 0);

        // pointer wrap: 10 push/pop pairs with two words in flight
        push(8'hB0, 1);
        push(8'hB1, 2);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = (i == 0) ? 8'hB0 : (i == 1) ? 8'hB1 : 8'hC0 + 8'(i - 2);
            bus.wr_pix   = 8'hC0 + 8'(i);
            bus.wr_valid = 1'b1;
            bus.req      = 1'b1;
            tick();
            bus.wr_valid = 1'b0;
            chk("wrap_pix", 32'(bus.pix_out), 32'(e));
            chk("wrap_fill", 32'(bus.fill), 32'd2);
            bus.req = 1'b0;
            tick();
        end
        pop(8'hC8, 1);
        pop(8'hC9, 0);

        // reset during HOLD, with a write presented on the reset edge
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i), i + 1);
        bus.req = 1'b1;
        tick();
        chk("pre_rst_ack", 32'(bus.ack), 32'd1);
        chk("pre_rst_fill", 32'(bus.fill), 32'd3);
        reset        = 1'b1;
        bus.wr_pix   = 8'hEE;
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        chk("hrst_ack", 32'(bus.ack), 32'd0);
        chk("hrst_fill", 32'(bus.fill), 32'd0);
        chk("hrst_pix", 32'(bus.pix_out), 32'd0);
        reset = 1'b0;
        #1;
        chk("hrst_wr_ready", 32'(bus.wr_ready), 32'd1);
        tick();
        chk("post_rst_no_pop", 32'(bus.ack), 32'd0);
        bus.req = 1'b0;
        tick();
        push(8'hE5, 1);
        pop(8'hE5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8, width of one pixel word.
REQ-002 Parameter LENGTH, default 8, width of the fill-level output.
REQ-003 Parameter DEPTH, default 16, storage entries; power of two, 2 <= DEPTH <= 2**LENGTH-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-006 wr_pix  input  PIXEL_WIDTH  pixel from the rasterizer lane.
REQ-007 wr_valid  input  1  wr_pix valid this cycle.
REQ-008 wr_ready  output  1  FIFO can accept a write this cycle.
REQ-009 fill  output  LENGTH  number of stored entries, 0..DEPTH; drives the contention tree fill_N input.
REQ-010 req  input  1  pop request from the contention tree, 4-phase.
REQ-011 ack  output  1  popped pixel valid on pix_out.
REQ-012 pix_out  output  PIXEL_WIDTH  popped pixel; drives the contention tree pix_in_N input.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH words with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 wr_ready SHALL be combinational: 1 when fill < DEPTH and reset = 0, else 0.
REQ-015 A write SHALL occur on an edge where wr_valid = 1 and wr_ready = 1: store wr_pix at the write pointer, then advance the pointer.
REQ-016 wr_valid while wr_ready = 0 SHALL be ignored, with no state change.
REQ-017 The pop FSM SHALL have two states: IDLE (ack = 0) and HOLD (ack = 1).
REQ-018 IDLE -> HOLD SHALL occur on an edge with req = 1 and fill > 0 (value before that edge):
- load pix_out with the head entry;
- advance the read pointer.
REQ-019 IDLE with req = 1 and fill = 0 SHALL stay in IDLE with ack = 0; the pop happens on the first edge where fill > 0.
REQ-020 A word written on edge N SHALL NOT be popped before edge N+1; there is no write-through.
REQ-021 HOLD SHALL persist while req = 1, holding ack = 1 and pix_out stable.
REQ-022 HOLD -> IDLE SHALL occur on the edge where req = 0; exactly one pop per req assertion.
REQ-023 ack SHALL be registered: it rises the cycle after the popping edge, so req-to-ack latency is 1 cycle minimum.
REQ-024 pix_out SHALL hold its last popped value in IDLE.
REQ-025 fill SHALL be a registered count updated each edge:
- +1 on write only;
- -1 on pop only;
- unchanged on a simultaneous write and pop, or on neither.
REQ-026 Simultaneous write and pop when fill = DEPTH cannot occur, because wr_ready = 0.
REQ-027 Simultaneous write and pop when fill = 1 SHALL leave fill = 1, with the new word at the head.
REQ-028 fill SHALL never exceed DEPTH and never go below 0.

Reset
REQ-029 On an edge with reset = 1, the block SHALL set:
- fill = 0, both pointers = 0;
- FSM = IDLE, ack = 0, pix_out = 0.
REQ-030 Reset SHALL discard stored contents; storage RAM need not be cleared.
REQ-031 Reset asserted during HOLD SHALL drop ack on the next edge, regardless of req.
REQ-032 Writes and pops presented on a reset edge SHALL be ignored.

Verification (DEPTH = 4, LENGTH = 8, PIXEL_WIDTH = 8)
REQ-033 Write 0x11, 0x22, 0x33 on consecutive cycles -> fill = 1, 2, 3; then req = 1 -> ack = 1 next cycle, pix_out = 0x11, fill = 2; req = 0 -> ack = 0.
REQ-034 Write 5 words 0xA0..0xA4 back-to-back -> wr_ready = 0 after the 4th, fill = 4, 0xA4 dropped; four pops return 0xA0..0xA3.
REQ-035 req = 1 with fill = 0 for 3 cycles, then write 0x5C -> fill = 1, pop on the next edge, ack = 1 with pix_out = 0x5C, fill back to 0.
REQ-036 fill = 2, write 0x77 on the same edge as a pop -> fill stays 2, ack = 1.
REQ-037 Run 10 write/pop pairs through DEPTH = 4 -> data order preserved across pointer wrap.
REQ-038 reset = 1 during HOLD with fill = 3 -> next cycle: ack = 0, fill = 0, pix_out = 0, wr_ready = 1 after reset deasserts.
